// File: rtl/div_issue_ctrl.sv
// Issue controller for the signed/unsigned AXI-stream divider IPs: one op in flight, flush-safe.
// Optional macro DIV_ZERO_BYPASS_EN answers a zero divisor locally without touching the IPs.
module div_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [DATA_W-1:0]   req_src1,
    input  logic [DATA_W-1:0]   req_src2,
    input  logic                flush,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_result,
    output logic                busy,
    output logic                s_tvalid,
    input  logic                s_dividend_tready,
    input  logic                s_divisor_tready,
    input  logic                s_dout_tvalid,
    input  logic [2*DATA_W-1:0] s_dout_tdata,
    output logic                u_tvalid,
    input  logic                u_dividend_tready,
    input  logic                u_divisor_tready,
    input  logic                u_dout_tvalid,
    input  logic [2*DATA_W-1:0] u_dout_tdata,
    output logic [DATA_W-1:0]   div_dividend,
    output logic [DATA_W-1:0]   div_divisor
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, CANCEL} state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   dividend_q, divisor_q, result_q;
    logic                dvd_done, dvs_done, cancel_q;
    logic                accept, tvalid, bypass;
    logic                dvd_tready, dvs_tready, dvd_ok, dvs_ok, hs_done;
    logic                dout_vld;
    logic [2*DATA_W-1:0] dout;

    assign req_ready    = (state == IDLE) && !flush;
    assign accept       = req_valid && req_ready;
    assign busy         = (state != IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_result  = result_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

    // Single shared tvalid, steered to the IP picked by op[1]
    assign tvalid   = (state == ISSUE);
    assign s_tvalid = tvalid && !op_q[1];
    assign u_tvalid = tvalid &&  op_q[1];

    assign dvd_tready = op_q[1] ? u_dividend_tready : s_dividend_tready;
    assign dvs_tready = op_q[1] ? u_divisor_tready  : s_divisor_tready;
    assign dout_vld   = op_q[1] ? u_dout_tvalid     : s_dout_tvalid;
    assign dout       = op_q[1] ? u_dout_tdata      : s_dout_tdata;

    // A channel is done if it completed earlier or completes this cycle
    assign dvd_ok  = dvd_done || dvd_tready;
    assign dvs_ok  = dvs_done || dvs_tready;
    assign hs_done = dvd_ok && dvs_ok;

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = (req_src2 == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = bypass ? RESP : ISSUE;
            ISSUE:  if (hs_done) state_nxt = (cancel_q || flush) ? CANCEL : WAIT;
            // A result landing in the same cycle as the flush is already drained
            WAIT:   if (flush) state_nxt = dout_vld ? IDLE : CANCEL;
                    else if (dout_vld) state_nxt = RESP;
            RESP:   if (flush || resp_ready) state_nxt = IDLE;
            CANCEL: if (dout_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            dvd_done   <= 1'b0;
            dvs_done   <= 1'b0;
            cancel_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= req_op;
                dividend_q <= req_src1;
                divisor_q  <= req_src2;
                dvd_done   <= 1'b0;
                dvs_done   <= 1'b0;
                cancel_q   <= 1'b0;
                if (bypass) result_q <= req_op[0] ? req_src1 : '1;
            end
            if (state == ISSUE) begin
                dvd_done <= dvd_ok;
                dvs_done <= dvs_ok;
                if (flush) cancel_q <= 1'b1;
            end
            if (state == WAIT && dout_vld && !flush)
                result_q <= op_q[0] ? dout[DATA_W-1:0] : dout[2*DATA_W-1:DATA_W];
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl with behavioural divider-IP models and a result/timing reference.
module tb_div_issue_ctrl;

    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_ready;
    logic [1:0]  req_op = 0;
    logic [31:0] req_src1 = 0, req_src2 = 0;
    logic        flush = 0;
    logic        resp_valid, resp_ready = 0;
    logic [31:0] resp_result;
    logic        busy;
    logic        s_tvalid, s_dividend_tready = 0, s_divisor_tready = 0, s_dout_tvalid = 0;
    logic [63:0] s_dout_tdata = 0;
    logic        u_tvalid, u_dividend_tready = 0, u_divisor_tready = 0, u_dout_tvalid = 0;
    logic [63:0] u_dout_tdata = 0;
    logic [31:0] div_dividend, div_divisor;

    int n_chk = 0, n_err = 0;

    div_issue_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy),
        .s_tvalid(s_tvalid), .s_dividend_tready(s_dividend_tready),
        .s_divisor_tready(s_divisor_tready), .s_dout_tvalid(s_dout_tvalid),
        .s_dout_tdata(s_dout_tdata),
        .u_tvalid(u_tvalid), .u_dividend_tready(u_dividend_tready),
        .u_divisor_tready(u_divisor_tready), .u_dout_tvalid(u_dout_tvalid),
        .u_dout_tdata(u_dout_tdata),
        .div_dividend(div_dividend), .div_divisor(div_divisor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Divider IP behaviour; zero divisor returns a recognisable pattern so pass-through is visible
    function automatic logic [63:0] ip_model(input logic uns, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = a ^ 32'hA5A5_A5A5; r = ~a;
        end else if (uns) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0;
        end else begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    function automatic logic is_bypass(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
        return b == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        if (is_bypass(b)) return op[0] ? a : 32'hFFFF_FFFF;
        d = ip_model(op[1], a, b);
        return op[0] ? d[31:0] : d[63:32];
    endfunction

    // ---------------- IP models (both IPs share one process) ----------------
    int          cyc = 0, vcnt = 0, formed = 0, s_tv = 0, u_tv = 0;
    int          dly_dvd = 0, dly_dvs = 0, ip_lat = 4;
    logic        have_dvd = 0, have_dvs = 0;
    logic [31:0] cap_dvd, cap_dvs;
    int          pq_due[$];
    logic [63:0] pq_dat[$];
    logic        pq_u[$];
    logic        m_uns, m_tv, tr_dvd, tr_dvs;

    always @(negedge clk) begin
        cyc++;
        s_dout_tvalid = 0;
        u_dout_tvalid = 0;
        if (reset) begin
            pq_due.delete(); pq_dat.delete(); pq_u.delete();
            have_dvd = 0; have_dvs = 0; vcnt = 0;
            s_dividend_tready = 0; s_divisor_tready = 0;
            u_dividend_tready = 0; u_divisor_tready = 0;
        end else begin
            if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
                if (pq_u[0]) begin u_dout_tvalid = 1; u_dout_tdata = pq_dat[0]; end
                else         begin s_dout_tvalid = 1; s_dout_tdata = pq_dat[0]; end
                void'(pq_due.pop_front()); void'(pq_dat.pop_front()); void'(pq_u.pop_front());
                chk("dout_while_busy", busy, 1);
            end
            chk("one_tvalid", s_tvalid & u_tvalid, 0);
            m_uns = u_tvalid;
            m_tv  = s_tvalid | u_tvalid;
            if (s_tvalid) s_tv++;
            if (u_tvalid) u_tv++;
            if (m_tv) vcnt++;
            // A channel holds one operand until the pair forms an op
            tr_dvd = m_tv && !have_dvd && (vcnt > dly_dvd);
            tr_dvs = m_tv && !have_dvs && (vcnt > dly_dvs);
            s_dividend_tready = m_uns ? 1'($urandom_range(0, 1)) : tr_dvd;
            s_divisor_tready  = m_uns ? 1'($urandom_range(0, 1)) : tr_dvs;
            u_dividend_tready = m_uns ? tr_dvd : 1'($urandom_range(0, 1));
            u_divisor_tready  = m_uns ? tr_dvs : 1'($urandom_range(0, 1));
            if (tr_dvd) begin have_dvd = 1; cap_dvd = div_dividend; end
            if (tr_dvs) begin have_dvs = 1; cap_dvs = div_divisor; end
            if (have_dvd && have_dvs) begin
                pq_due.push_back(cyc + ip_lat);
                pq_dat.push_back(ip_model(m_uns, cap_dvd, cap_dvs));
                pq_u.push_back(m_uns);
                formed++;
                have_dvd = 0; have_dvs = 0; vcnt = 0;
            end
        end
    end

    // ---------------- one operation, end to end ----------------
    // fl: relative cycle to pulse flush (-1 none); rr: cycles resp_ready is held low
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dd, input int ds, input int lt, input int fl, input int rr);
        int c, exp_c, f0, n;
        logic [31:0] exp_r;
        logic byp, cancel_exp;
        byp   = is_bypass(b);
        exp_r = exp_result(op, a, b);
        exp_c = byp ? 1 : ((dd > ds ? dd : ds) + 1 + lt + 1);
        cancel_exp = (fl > 0) && (fl < exp_c);
        dly_dvd = dd; dly_dvs = ds; ip_lat = lt;
        @(negedge clk);
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
        resp_ready = 0; flush = 0;
        f0 = formed; s_tv = 0; u_tv = 0;
        #1 chk("req_ready_idle", req_ready, 1);
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            req_valid = 0;
            flush = (c == fl);
            #1;
            if (resp_valid) break;
            if (fl > 0 && c >= fl && !busy) break;
        end
        chk("resp_rise", resp_valid, !cancel_exp);
        if (resp_valid) begin
            chk("resp_cycle", c, exp_c);
            chk("resp_result", resp_result, exp_r);
            if (c == fl) begin
                @(negedge clk); flush = 0;
                #1 chk("flush_drop_valid", resp_valid, 0);
                chk("flush_drop_busy", busy, 0);
            end else begin
                for (int i = 0; i < rr; i++) begin
                    @(negedge clk);
                    #1 chk("hold_valid", resp_valid, 1);
                    chk("hold_result", resp_result, exp_r);
                    chk("hold_req_ready", req_ready, 0);
                end
                resp_ready = 1;
                @(negedge clk); resp_ready = 0;
                #1 chk("resp_single", resp_valid, 0);
            end
        end
        flush = 0;
        n = 0;
        while ((busy || pq_due.size() > 0) && n < 200) begin @(negedge clk); n++; end
        chk("drained", busy, 0);
        chk("ip_ops", formed - f0, byp ? 0 : 1);
        chk("tvalid_cycles", op[1] ? u_tv : s_tv, byp ? 0 : (dd > ds ? dd : ds) + 1);
        chk("other_tvalid", op[1] ? s_tv : u_tv, 0);
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_tvalid", {s_tvalid, u_tvalid}, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_operands", {div_dividend, div_divisor}, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        run_op(2'b00, 32'd100, 32'd7, 0, 0, 8, -1, 0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0, 0, 3, -1, 0);
        run_op(2'b10, 32'hFFFF_FFFE, 32'd2, 0, 0, 5, -1, 0);
        run_op(2'b00, 32'd1000, 32'd10, 0, 3, 3, -1, 0);
        run_op(2'b01, 32'd77, 32'd5, 4, 4, 4, 2, 0);   // flush during a stalled ISSUE
        run_op(2'b00, 32'd77, 32'd5, 0, 0, 2, -1, 0);
        run_op(2'b11, 32'd123456, 32'd1000, 1, 0, 2, -1, 5);
        run_op(2'b10, 32'd999, 32'd9, 0, 0, 6, 4, 0);  // flush in WAIT
        run_op(2'b00, 32'd50, 32'd3, 0, 0, 2, 4, 0);   // flush in RESP
        run_op(2'b00, 32'd5, 32'd0, 0, 0, 3, -1, 0);
        run_op(2'b11, 32'd5, 32'd0, 0, 0, 3, -1, 0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd3; flush = 1;
        #1 chk("flush_idle_ready", req_ready, 0);
        @(negedge clk); req_valid = 0; flush = 0;
        #1 chk("flush_idle_busy", busy, 0);

        // Asynchronous reset in WAIT
        dly_dvd = 0; dly_dvs = 0; ip_lat = 20;
        @(negedge clk);
        req_valid = 1; req_op = 2'b00; req_src1 = 32'd81; req_src2 = 32'd3;
        @(negedge clk); req_valid = 0;
        repeat (3) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_tvalid", {s_tvalid, u_tvalid}, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_result", resp_result, 0);
        chk("arst_operands", {div_dividend, div_divisor}, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a, b;
            int fl;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 16);
                2: b = -($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1;
            run_op(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(1, 10), fl, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
